// File: rtl/priority_enc_rr_if.sv
// rtl/priority_enc_rr_if.sv - request/result bundle for priority_enc_rr
// master drives requests and out_ready; slave (the encoder) returns registered results.
interface priority_enc_rr_if #(
    parameter int N = 8
) ();
    localparam int W = $clog2(N);

    logic [N-1:0] req;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] idx;
    logic [N-1:0] grant;

    modport master (
        output req,
        output out_ready,
        input  out_valid,
        input  idx,
        input  grant
    );

    modport slave (
        input  req,
        input  out_ready,
        output out_valid,
        output idx,
        output grant
    );
endinterface

// File: rtl/priority_enc_rr.sv
// rtl/priority_enc_rr.sv - registered priority encoder, downward search from pointer p with wrap
// Define PRIORITY_ENC_RR_ROUND_ROBIN_EN for rotating priority; otherwise the highest set bit wins.
module priority_enc_rr #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    priority_enc_rr_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [W-1:0] PTR_TOP = W'(N - 1);

    state_t       state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] grant_q, grant_d;
    logic [W-1:0] ptr;
    logic         enc_hit;
    logic [W-1:0] enc_idx;
    logic [W-1:0] cand;
    logic         load;

`ifdef PRIORITY_ENC_RR_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = PTR_TOP;
`endif

    // Candidate k steps below ptr, wrapping modulo N (never modulo 2^W).
    always_comb begin
        enc_hit = 1'b0;
        enc_idx = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            if (k <= int'(ptr)) begin
                cand = ptr - W'(k);
            end else begin
                cand = ptr + W'(N - k);
            end
            if (!enc_hit && (bus.req[cand] == 1'b1)) begin
                enc_hit = 1'b1;
                enc_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            grant_q <= '0;
`ifdef PRIORITY_ENC_RR_ROUND_ROBIN_EN
            ptr_q   <= PTR_TOP;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
`ifdef PRIORITY_ENC_RR_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enc_hit) begin
                    state_d = HOLD;
                    load    = 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (enc_hit) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            idx_d   = enc_idx;
            grant_d = N'(1) << enc_idx;
        end
`ifdef PRIORITY_ENC_RR_ROUND_ROBIN_EN
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = (enc_idx == '0) ? PTR_TOP : enc_idx - 1'b1;
        end
`endif
    end

    always_comb begin
        bus.out_valid = (state_q == HOLD);
        bus.idx       = idx_q;
        bus.grant     = grant_q;
    end
endmodule

// File: tb/tb_priority_enc_rr.sv
// tb/tb_priority_enc_rr.sv - self-checking bench for priority_enc_rr at N=8 and N=5
// Behavioural model plus directed literal checks; honours PRIORITY_ENC_RR_ROUND_ROBIN_EN.
module tb_priority_enc_rr;
`ifdef PRIORITY_ENC_RR_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    priority_enc_rr_if #(.N(8)) bus_a ();
    priority_enc_rr_if #(.N(5)) bus_b ();

    priority_enc_rr #(.N(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    priority_enc_rr #(.N(5)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // First set bit scanning down from p, wrapping from 0 to n-1; -1 when none.
    function automatic int pick(input int n, input logic [7:0] r, input int p);
        for (int k = 0; k < n; k++) begin
            int c;
            c = ((p - k) % n + n) % n;
            if (r[c[2:0]]) return c;
        end
        return -1;
    endfunction

    int ma_idx, ma_p, mb_idx, mb_p;
    bit ma_valid, mb_valid;
    int wa, wb;
    assign wa = pick(8, bus_a.req, ma_p);
    assign wb = pick(5, {3'b000, bus_b.req}, mb_p);

    always @(posedge clk) begin
        if (rst) begin
            ma_valid <= 1'b0; ma_idx <= 0; ma_p <= 7;
            mb_valid <= 1'b0; mb_idx <= 0; mb_p <= 4;
        end else begin
            if (!ma_valid || bus_a.out_ready) begin
                if (wa < 0) begin
                    ma_valid <= 1'b0; ma_idx <= 0;
                end else begin
                    ma_valid <= 1'b1; ma_idx <= wa;
                    if (RR) ma_p <= (wa + 7) % 8;
                end
            end
            if (!mb_valid || bus_b.out_ready) begin
                if (wb < 0) begin
                    mb_valid <= 1'b0; mb_idx <= 0;
                end else begin
                    mb_valid <= 1'b1; mb_idx <= wb;
                    if (RR) mb_p <= (wb + 4) % 5;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("a_valid", int'(bus_a.out_valid), int'(ma_valid));
        chk("a_idx",   int'(bus_a.idx),       ma_idx);
        chk("a_grant", int'(bus_a.grant),     ma_valid ? (1 << ma_idx) : 0);
        chk("b_valid", int'(bus_b.out_valid), int'(mb_valid));
        chk("b_idx",   int'(bus_b.idx),       mb_idx);
        chk("b_grant", int'(bus_b.grant),     mb_valid ? (1 << mb_idx) : 0);
        chk("b_idx_range", int'(bus_b.idx < 3'd5), 1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus_a.req = '0; bus_a.out_ready = 1'b0;
        bus_b.req = '0; bus_b.out_ready = 1'b0;

        chk("model_pick_basic", pick(8, 8'h26, 7), 5);
        chk("model_pick_wrap",  pick(5, 8'h11, 3), 0);
        chk("model_pick_none",  pick(8, 8'h00, 7), -1);

        step(); step();
        chk("reset_valid", int'(bus_a.out_valid), 0);
        chk("reset_idx",   int'(bus_a.idx), 0);
        chk("reset_grant", int'(bus_a.grant), 0);
        chk("reset_b_valid", int'(bus_b.out_valid), 0);

        rst = 1'b0;
        bus_b.req = 5'b10001; bus_b.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_valid", int'(bus_a.out_valid), 0);
            chk("idle_idx",   int'(bus_a.idx), 0);
            chk("idle_grant", int'(bus_a.grant), 0);
            if (i < 3) begin
                chk("n5_valid", int'(bus_b.out_valid), 1);
                chk("n5_idx", int'(bus_b.idx), (i == 1 && RR) ? 0 : 4);
            end
        end

        bus_a.req = 8'b0010_0110; bus_a.out_ready = 1'b0;
        step();
        chk("first_valid", int'(bus_a.out_valid), 1);
        chk("first_idx",   int'(bus_a.idx), 5);
        chk("first_grant", int'(bus_a.grant), 'h20);

        bus_a.req = 8'h01;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_idx", int'(bus_a.idx), 5);
            chk("hold_valid", int'(bus_a.out_valid), 1);
        end
        bus_a.out_ready = 1'b1;
        step();
        chk("release_idx", int'(bus_a.idx), 0);
        chk("release_grant", int'(bus_a.grant), 'h01);

        bus_a.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("all_req_idx", int'(bus_a.idx), RR ? (7 - (i % 8)) : 7);
        end

        rst = 1'b1;
        step();
        rst = 1'b0; bus_a.req = 8'h08; bus_a.out_ready = 1'b1;
        step();
        chk("pre_rst_idx", int'(bus_a.idx), 3);
        bus_a.out_ready = 1'b0; rst = 1'b1;
        step();
        chk("rst_in_hold_valid", int'(bus_a.out_valid), 0);
        rst = 1'b0; bus_a.req = 8'hFF; bus_a.out_ready = 1'b1;
        step();
        chk("post_rst_idx", int'(bus_a.idx), 7);
        chk("post_rst_valid", int'(bus_a.out_valid), 1);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 3))
                0:       bus_a.req = '0;
                1:       bus_a.req = 8'(1 << $urandom_range(0, 7));
                default: bus_a.req = 8'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       bus_b.req = '0;
                1:       bus_b.req = 5'(1 << $urandom_range(0, 4));
                default: bus_b.req = 5'($urandom);
            endcase
            bus_a.out_ready = ($urandom_range(0, 2) != 0);
            bus_b.out_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
